pipe_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the fixed 3-stage hazard/forwarding unit of the ARM pipeline.

---
 rtl/pipe_hazard_scoreboard_pkg.sv | 21 ++
 rtl/pipe_hazard_scoreboard_src_match.sv | 35 +++
 rtl/pipe_hazard_scoreboard.sv | 97 +++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared constants and helpers for the in-flight writer scoreboard.
// An entry is packed as {rd, ld, vld}, with field offsets given below.
package pipe_hazard_scoreboard_pkg;
   localparam int unsigned NUM_SRC_DEF    = 3;
   localparam int unsigned REG_AW_DEF     = 4;
   localparam int unsigned FWD_STAGES_DEF = 3;
   localparam int unsigned MEM_LAT_DEF    = 1;
   localparam int unsigned PC_REG_DEF     = 15;

   localparam int unsigned ENT_VLD = 0;
   localparam int unsigned ENT_LD  = 1;
   localparam int unsigned ENT_RD  = 2;

   function automatic int unsigned ent_w(input int unsigned aw);
      return aw + 2;
   endfunction

   function automatic int unsigned sel_w(input int unsigned stages);
      return $clog2(stages + 1);
   endfunction
endpackage

// File: rtl/pipe_hazard_scoreboard_src_match.sv
// Checks one register source against every scoreboard entry.
// It returns the nearest matching stage and flags a hit on a load in stage 1.
module hazard_src_match
   import pipe_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned REG_AW     = REG_AW_DEF,
   parameter int unsigned FWD_STAGES = FWD_STAGES_DEF,
   parameter int unsigned PC_REG     = PC_REG_DEF,
   localparam int unsigned EW        = ent_w(REG_AW),
   localparam int unsigned SELW      = sel_w(FWD_STAGES)
) (
   input  logic [REG_AW-1:0]        src_i,
   input  logic                     used_i,
   input  logic [FWD_STAGES*EW-1:0] ent_i,
   output logic [SELW-1:0]          sel_o,
   output logic                     ld_hit_o
);
   logic hit_ld;

   // Walk from the oldest stage toward the youngest so the nearest match is written last.
   always_comb begin
      sel_o  = '0;
      hit_ld = 1'b0;
      if (used_i && (src_i != REG_AW'(PC_REG))) begin
         for (int k = FWD_STAGES; k >= 1; k--) begin
            if (ent_i[(k-1)*EW + ENT_VLD] &&
                (ent_i[(k-1)*EW + ENT_RD +: REG_AW] == src_i)) begin
               sel_o  = SELW'(k);
               hit_ld = ent_i[(k-1)*EW + ENT_LD];
            end
         end
      end
      ld_hit_o = (sel_o == SELW'(1)) && hit_ld;
   end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard unit. It keeps a scoreboard of in-flight register writers and drives
// the forwarding selects, load-use bubbles and the multi-cycle memory hold.
module pipe_hazard_scoreboard
   import pipe_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
   parameter int unsigned REG_AW     = REG_AW_DEF,
   parameter int unsigned FWD_STAGES = FWD_STAGES_DEF,
   parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
   parameter int unsigned PC_REG     = PC_REG_DEF
) (
   input  logic                                           CLK,
   input  logic                                           CLR,
   input  logic                                           id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]                      id_src_reg,
   input  logic [NUM_SRC-1:0]                             id_src_used,
   input  logic [REG_AW-1:0]                              id_rd,
   input  logic                                           id_rf_en,
   input  logic                                           id_load,
   input  logic                                           flush,
   output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0]        fwd_sel,
   output logic                                           pc_le,
   output logic                                           ifid_le,
   output logic                                           nop_insert,
   output logic                                           mem_hold
);
   localparam int unsigned EW   = ent_w(REG_AW);
   localparam int unsigned SELW = sel_w(FWD_STAGES);

   logic [FWD_STAGES*EW-1:0] ent_q, ent_d;
   logic [NUM_SRC-1:0]       ld_hit;
   logic [EW-1:0]            id_rec;
   logic                     hold, stall;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      hazard_src_match #(
         .REG_AW    (REG_AW),
         .FWD_STAGES(FWD_STAGES),
         .PC_REG    (PC_REG)
      ) u_match (
         .src_i   (id_src_reg[gi*REG_AW +: REG_AW]),
         .used_i  (id_src_used[gi]),
         .ent_i   (ent_q),
         .sel_o   (fwd_sel[gi*SELW +: SELW]),
         .ld_hit_o(ld_hit[gi])
      );
   end

   // A flush kills the consumer, so no bubble is needed; the hold freezes everything anyway.
   assign stall      = (|ld_hit) & ~flush & ~hold;
   assign nop_insert = stall;
   assign mem_hold   = hold;
   assign pc_le      = ~hold & ~stall;
   assign ifid_le    = ~hold & ~stall;

   always_comb begin
      id_rec                  = '0;
      id_rec[ENT_VLD]         = id_valid & id_rf_en & ~stall & ~flush;
      id_rec[ENT_LD]          = id_load;
      id_rec[ENT_RD +: REG_AW] = id_rd;
   end

   always_comb begin
      ent_d = ent_q;
      if (!hold) begin
         ent_d         = ent_q << EW;
         ent_d[EW-1:0] = id_rec;
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) ent_q <= '0;
      else     ent_q <= ent_d;
   end

   if (MEM_LAT > 1) begin : g_hold
      logic [31:0] hold_cnt_q, hold_cnt_d;

      // The load leaves stage 1 on the same edge that arms the counter, because hold is still 0 then.
      always_comb begin
         hold_cnt_d = hold_cnt_q;
         if (hold_cnt_q != 32'd0)
            hold_cnt_d = hold_cnt_q - 32'd1;
         else if (ent_q[ENT_VLD] && ent_q[ENT_LD])
            hold_cnt_d = 32'(MEM_LAT - 1);
      end

      always_ff @(posedge CLK) begin
         if (CLR) hold_cnt_q <= '0;
         else     hold_cnt_q <= hold_cnt_d;
      end

      assign hold = (hold_cnt_q != 32'd0);
   end else begin : g_nohold
      assign hold = 1'b0;
   end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed scenarios, then random traffic. It drives a
// MEM_LAT=1 instance (a) and a MEM_LAT=3 instance (b) and checks both against a pipeline model.
module tb_pipe_hazard_scoreboard;
   localparam int NS = 3, AW = 4, SELW = 2;

   logic              CLK = 1'b0;
   logic              CLR;
   logic              id_valid, id_rf_en, id_load, flush;
   logic [NS*AW-1:0]  id_src_reg;
   logic [NS-1:0]     id_src_used;
   logic [AW-1:0]     id_rd;
   logic [NS*SELW-1:0] fsel_a, fsel_b;
   logic              pc_a, pc_b, ifid_a, ifid_b, nop_a, nop_b, mh_a, mh_b;

   int n_chk = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   pipe_hazard_scoreboard #(.MEM_LAT(1)) dut_a (
      .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_src_reg(id_src_reg),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
      .flush(flush), .fwd_sel(fsel_a), .pc_le(pc_a), .ifid_le(ifid_a),
      .nop_insert(nop_a), .mem_hold(mh_a));

   pipe_hazard_scoreboard #(.MEM_LAT(3)) dut_b (
      .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_src_reg(id_src_reg),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
      .flush(flush), .fwd_sel(fsel_b), .pc_le(pc_b), .ifid_le(ifid_b),
      .nop_insert(nop_b), .mem_hold(mh_b));

   // Model: the in-flight instructions per stage, plus the remaining memory-hold cycles.
   typedef struct {
      bit       vld;
      bit [3:0] rd;
      bit       ld;
   } rec_t;

   rec_t        sb [2][1:3];
   int unsigned hcnt [2];
   int unsigned lat  [2] = '{1, 3};
   bit [5:0]    e_sel [2];
   bit          e_nop [2], e_pc [2], e_mh [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_eval(input int d);
      bit       busy;
      bit       luse;
      bit [3:0] s;
      int       near;
      busy = (hcnt[d] != 0);
      luse = 1'b0;
      for (int i = 0; i < NS; i++) begin
         s    = id_src_reg[i*AW +: AW];
         near = 0;
         if (id_src_used[i] && s != 4'd15)
            for (int k = 1; k <= 3; k++)
               if (near == 0 && sb[d][k].vld && sb[d][k].rd == s) near = k;
         e_sel[d][i*SELW +: SELW] = 2'(near);
         if (near == 1 && sb[d][1].ld) luse = 1'b1;
      end
      e_nop[d] = luse && !busy && !flush;
      e_pc[d]  = !busy && !e_nop[d];
      e_mh[d]  = busy;
   endfunction

   function automatic void model_step(input int d);
      if (CLR) begin
         for (int k = 1; k <= 3; k++) sb[d][k] = '{1'b0, 4'd0, 1'b0};
         hcnt[d] = 0;
      end else if (hcnt[d] != 0) begin
         hcnt[d]--;
      end else begin
         if (lat[d] > 1 && sb[d][1].vld && sb[d][1].ld) hcnt[d] = lat[d] - 1;
         sb[d][3] = sb[d][2];
         sb[d][2] = sb[d][1];
         sb[d][1] = '{id_valid && id_rf_en && !e_nop[d] && !flush, id_rd, id_load};
      end
   endfunction

   task automatic drive(input bit v, input bit [3:0] s0, input bit [3:0] s1, input bit [3:0] s2,
                        input bit [2:0] u, input bit [3:0] rd, input bit we, input bit ld,
                        input bit fl, input bit cl);
      id_valid    = v;
      id_src_reg  = {s2, s1, s0};
      id_src_used = u;
      id_rd       = rd;
      id_rf_en    = we;
      id_load     = ld;
      flush       = fl;
      CLR         = cl;
   endtask

   // Settle the inputs, then compare both instances against the model.
   task automatic tick();
      #1;
      for (int d = 0; d < 2; d++) model_eval(d);
      chk("a.fwd_sel", 32'(fsel_a), 32'(e_sel[0]));
      chk("a.pc_le",   32'(pc_a),   32'(e_pc[0]));
      chk("a.ifid_le", 32'(ifid_a), 32'(e_pc[0]));
      chk("a.nop",     32'(nop_a),  32'(e_nop[0]));
      chk("a.mem_hold", 32'(mh_a),  32'(e_mh[0]));
      chk("b.fwd_sel", 32'(fsel_b), 32'(e_sel[1]));
      chk("b.pc_le",   32'(pc_b),   32'(e_pc[1]));
      chk("b.ifid_le", 32'(ifid_b), 32'(e_pc[1]));
      chk("b.nop",     32'(nop_b),  32'(e_nop[1]));
      chk("b.mem_hold", 32'(mh_b),  32'(e_mh[1]));
   endtask

   task automatic adv();
      @(posedge CLK);
      for (int d = 0; d < 2; d++) model_step(d);
      @(negedge CLK);
   endtask

   task automatic clr_cycle();
      drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
      tick();
      adv();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         e_nop[d] = 1'b0;
         hcnt[d]  = 0;
      end
      drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
      @(negedge CLK);
      adv();

      // Outputs after reset
      drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      tick();
      chk("rst.fwd_sel", 32'(fsel_a), 32'd0);
      chk("rst.pc_le",   32'(pc_a),   32'd1);
      chk("rst.ifid_le", 32'(ifid_a), 32'd1);
      chk("rst.nop",     32'(nop_a),  32'd0);
      chk("rst.mem_hold", 32'(mh_b),  32'd0);
      adv();

      // ADD R1 forwarded from EX, MEM, WB, then from the register file
      drive(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0); tick(); adv();
      drive(1, 1, 0, 0, 3'b001, 4, 0, 0, 0, 0); tick(); chk("fwd.ex",  32'(fsel_a[1:0]), 32'd1); adv();
      tick(); chk("fwd.mem", 32'(fsel_a[1:0]), 32'd2); adv();
      tick(); chk("fwd.wb",  32'(fsel_a[1:0]), 32'd3); adv();
      tick(); chk("fwd.rf",  32'(fsel_a[1:0]), 32'd0); adv();

      // Load-use: one bubble, then forward from MEM
      drive(1, 0, 0, 0, 3'b000, 2, 1, 1, 0, 0); tick(); adv();
      drive(1, 0, 2, 0, 3'b010, 5, 1, 0, 0, 0); tick();
      chk("lu.pc_le",   32'(pc_a),   32'd0);
      chk("lu.ifid_le", 32'(ifid_a), 32'd0);
      chk("lu.nop",     32'(nop_a),  32'd1);
      chk("lu.sel",     32'(fsel_a[3:2]), 32'd1);
      adv();
      tick();
      chk("lu.sel_mem", 32'(fsel_a[3:2]), 32'd2);
      chk("lu.release", 32'(pc_a), 32'd1);
      adv();
      clr_cycle();

      // Nearest writer wins; R15 and unused sources never forward
      drive(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0); tick(); adv();
      drive(1, 0, 0, 0, 3'b000, 15, 1, 0, 0, 0); tick(); adv();
      drive(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0); tick(); adv();
      drive(1, 15, 3, 3, 3'b101, 0, 0, 0, 0, 0); tick();
      chk("near.pc",     32'(fsel_a[1:0]), 32'd0);
      chk("near.unused", 32'(fsel_a[3:2]), 32'd0);
      chk("near.sel",    32'(fsel_a[5:4]), 32'd1);
      adv();

      // MEM_LAT=3: two frozen cycles after the load reaches MEM
      clr_cycle();
      drive(1, 0, 0, 0, 3'b000, 6, 1, 1, 0, 0); tick(); adv();
      drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0); tick(); chk("mh.pre", 32'(mh_b), 32'd0); adv();
      drive(1, 6, 0, 0, 3'b001, 0, 0, 0, 0, 0); tick();
      chk("mh.c1", 32'(mh_b), 32'd1);
      chk("mh.c1_pc", 32'(pc_b), 32'd0);
      chk("mh.c1_sel", 32'(fsel_b[1:0]), 32'd2);
      adv();
      tick();
      chk("mh.c2", 32'(mh_b), 32'd1);
      chk("mh.c2_nop", 32'(nop_b), 32'd0);
      adv();
      tick();
      chk("mh.done", 32'(mh_b), 32'd0);
      chk("mh.done_sel", 32'(fsel_b[1:0]), 32'd2);
      chk("mh.done_pc", 32'(pc_b), 32'd1);
      adv();

      // Flush beats load-use stall; CLR aborts an active hold
      clr_cycle();
      drive(1, 0, 0, 0, 3'b000, 7, 1, 1, 0, 0); tick(); adv();
      drive(1, 7, 0, 0, 3'b001, 0, 0, 0, 1, 0); tick();
      chk("fl.pc_le", 32'(pc_a), 32'd1);
      chk("fl.ifid_le", 32'(ifid_a), 32'd1);
      chk("fl.nop", 32'(nop_a), 32'd0);
      adv();
      drive(1, 7, 0, 0, 3'b001, 0, 0, 0, 0, 1); tick();
      chk("fl.sel_mem", 32'(fsel_a[1:0]), 32'd2);
      chk("clr.hold_on", 32'(mh_b), 32'd1);
      adv();
      drive(1, 7, 0, 0, 3'b001, 0, 0, 0, 0, 0); tick();
      chk("clr.hold_off", 32'(mh_b), 32'd0);
      chk("clr.sel_b", 32'(fsel_b), 32'd0);
      chk("clr.sel_a", 32'(fsel_a), 32'd0);
      adv();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         bit [3:0] r [4];
         for (int j = 0; j < 4; j++)
            r[j] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
         drive($urandom_range(0, 7) != 0, r[0], r[1], r[2], 3'($urandom), r[3],
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
         tick();
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
